// File: rtl/turf_command_monitor.sv
// turf_command_monitor: qualifies the TURF command stream with a lock/arming FSM,
// extracts trigger, run-command and firmware-byte fields, queues triggers in a FWFT FIFO
// and keeps trigger/drop/lock-loss statistics.
// Ports: sysclk_i/sysclk_rst_i clock and sync active-high reset; command_i/command_valid_i/
// command_locked_i command stream; clear_i statistics clear; trig_tdata/tvalid/tready AXI4-S
// trigger out; runcmd_o/runcmd_valid_o run-command strobe; fw_tdata/fw_tvalid firmware byte
// strobe; running_o armed indicator; trig_count_o/trig_drop_count_o/lock_loss_count_o statistics.
// Macro TURF_CMD_MON_FW_EN builds firmware-byte extraction; otherwise fw_* are tied 0.
module turf_command_monitor #(
  parameter int ARM_COUNT       = 4,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rst_i,
  input  logic [31:0] command_i,
  input  logic        command_valid_i,
  input  logic        command_locked_i,
  input  logic        clear_i,
  output logic [14:0] trig_tdata,
  output logic        trig_tvalid,
  input  logic        trig_tready,
  output logic [1:0]  runcmd_o,
  output logic        runcmd_valid_o,
  output logic [7:0]  fw_tdata,
  output logic        fw_tvalid,
  output logic        running_o,
  output logic [31:0] trig_count_o,
  output logic [15:0] trig_drop_count_o,
  output logic [15:0] lock_loss_count_o
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  typedef enum logic [1:0] {UNLOCKED, ARMING, RUNNING} state_t;
  state_t state_q, state_d;
  logic [7:0] arm_cnt_q, arm_cnt_d;
  logic valid_q, valid_d, clean_q, clean_d, trig_q, trig_d;
  logic [14:0] addr_q, addr_d, push_addr_q, push_addr_d;
  logic [1:0] run_q, run_d, runcmd_q, runcmd_d;
  logic push_q, push_d, runcmd_valid_q, runcmd_valid_d;
  logic dec, lock_loss;
  logic [14:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
  logic empty, full, pop, acc, drop;
  logic [31:0] trig_count_q, trig_count_d, base_trig;
  logic [15:0] drop_count_q, drop_count_d, base_drop, ll_count_q, ll_count_d, base_ll;
  // Input register stage; a command seen while unlocked is never qualified.
  always_comb begin
    valid_d = command_valid_i & command_locked_i;
    clean_d = command_i[23:22] == 2'b00;
    trig_d  = command_i[15];
    addr_d  = command_i[14:0];
    run_d   = command_i[17:16];
  end
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    lock_loss = 1'b0;
    case (state_q)
      UNLOCKED: if (command_locked_i) begin
        state_d   = ARMING;
        arm_cnt_d = '0;
      end
      ARMING: if (!command_locked_i) state_d = UNLOCKED;
      else if (valid_q) begin
        arm_cnt_d = clean_q ? arm_cnt_q + 8'd1 : 8'd0;
        if (clean_q && (arm_cnt_q + 8'd1) == 8'(ARM_COUNT)) state_d = RUNNING;
      end
      RUNNING: if (!command_locked_i) begin
        state_d   = UNLOCKED;
        lock_loss = 1'b1;
      end
      default: state_d = UNLOCKED;
    endcase
  end
  // Decode only in RUNNING, so the command that completes arming is not acted on.
  always_comb begin
    dec            = valid_q && state_q == RUNNING;
    push_d         = dec && trig_q;
    push_addr_d    = addr_q;
    runcmd_valid_d = dec && run_q != 2'b00;
    runcmd_d       = runcmd_valid_d ? run_q : 2'b00;
  end
  // A full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    occ      = wr_ptr_q - rd_ptr_q;
    empty    = occ == '0;
    full     = occ == PW'(DEPTH);
    pop      = !empty && trig_tready;
    acc      = push_q && (!full || pop);
    drop     = push_q && full && !pop;
    wr_ptr_d = wr_ptr_q + PW'(acc);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end
  // Clear and increment in the same cycle leaves the counter at 1.
  always_comb begin
    base_trig    = clear_i ? '0 : trig_count_q;
    base_drop    = clear_i ? '0 : drop_count_q;
    base_ll      = clear_i ? '0 : ll_count_q;
    trig_count_d = base_trig + 32'(acc);
    drop_count_d = (drop && base_drop != 16'hFFFF) ? base_drop + 16'd1 : base_drop;
    ll_count_d   = (lock_loss && base_ll != 16'hFFFF) ? base_ll + 16'd1 : base_ll;
  end
  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      state_q        <= UNLOCKED;
      arm_cnt_q      <= '0;
      valid_q        <= 1'b0;
      clean_q        <= 1'b0;
      trig_q         <= 1'b0;
      addr_q         <= '0;
      run_q          <= '0;
      push_q         <= 1'b0;
      push_addr_q    <= '0;
      runcmd_q       <= '0;
      runcmd_valid_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      trig_count_q   <= '0;
      drop_count_q   <= '0;
      ll_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      arm_cnt_q      <= arm_cnt_d;
      valid_q        <= valid_d;
      clean_q        <= clean_d;
      trig_q         <= trig_d;
      addr_q         <= addr_d;
      run_q          <= run_d;
      push_q         <= push_d;
      push_addr_q    <= push_addr_d;
      runcmd_q       <= runcmd_d;
      runcmd_valid_q <= runcmd_valid_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      trig_count_q   <= trig_count_d;
      drop_count_q   <= drop_count_d;
      ll_count_q     <= ll_count_d;
    end
  end
  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge sysclk_i) begin
    if (acc) mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= push_addr_q;
  end
`ifdef TURF_CMD_MON_FW_EN
  logic fw_flag_q, fw_flag_d, fw_valid_q, fw_valid_d;
  logic [7:0] fw_byte_q, fw_byte_d, fw_data_q, fw_data_d;
  logic unused_bits;
  always_comb begin
    fw_flag_d  = command_i[18];
    fw_byte_d  = command_i[31:24];
    fw_valid_d = dec && fw_flag_q;
    fw_data_d  = fw_valid_d ? fw_byte_q : 8'h00;
  end
  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      fw_flag_q  <= 1'b0;
      fw_byte_q  <= '0;
      fw_valid_q <= 1'b0;
      fw_data_q  <= '0;
    end else begin
      fw_flag_q  <= fw_flag_d;
      fw_byte_q  <= fw_byte_d;
      fw_valid_q <= fw_valid_d;
      fw_data_q  <= fw_data_d;
    end
  end
  assign fw_tdata    = fw_data_q;
  assign fw_tvalid   = fw_valid_q;
  assign unused_bits = ^command_i[21:19];
`else
  logic unused_bits;
  assign fw_tdata    = 8'h00;
  assign fw_tvalid   = 1'b0;
  assign unused_bits = ^{command_i[31:24], command_i[21:18]};
`endif
  assign trig_tvalid       = !empty;
  assign trig_tdata        = empty ? '0 : mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
  assign runcmd_o          = runcmd_q;
  assign runcmd_valid_o    = runcmd_valid_q;
  assign running_o         = state_q == RUNNING;
  assign trig_count_o      = trig_count_q;
  assign trig_drop_count_o = drop_count_q;
  assign lock_loss_count_o = ll_count_q;
endmodule
